// File: rtl/turn_pkg.sv
// Shared board geometry and turn FSM state encoding; the movement controller
// uses the same START_X/TILE_W/LAST_TILE for its flag-x check.
package turn_pkg;

    localparam int START_X   = 20;
    localparam int TILE_W    = 30;
    localparam int LAST_TILE = 20;
    localparam int DIE_MAX   = 6;
    localparam int TILE_BITS = 5;
    localparam int X_BITS    = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ROLL  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_OVER  = 3'd4
    } turn_state_t;

    // Screen x of a tile; 620 at the flag still fits in 10 bits.
    function automatic logic [X_BITS-1:0] tile_x(input logic [TILE_BITS-1:0] t);
        return X_BITS'(START_X) + X_BITS'(t) * X_BITS'(TILE_W);
    endfunction

endpackage

// File: rtl/die_counter.sv
// Free-running die: cycles 1..DIE_MAX on every clock edge, independent of game state.
module die_counter
    import turn_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [2:0] value_o
);

    logic [2:0] value_q;
    logic [2:0] value_d;

    assign value_d = (value_q == 3'(DIE_MAX)) ? 3'd1 : value_q + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) value_q <= 3'd1;
        else        value_q <= value_d;
    end

    assign value_o = value_q;

endmodule

// File: rtl/turn_manager.sv
// Two-player turn sequencer feeding the movement controller.
// EXACT_FINISH_EN: overshooting the flag bounces back instead of clamping.
module turn_manager
    import turn_pkg::*;
#(
    parameter int DONE_TIMEOUT = 127
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              roll_req,
    input  logic              turn_done,
    output logic [X_BITS-1:0] player1_pos_x,
    output logic [X_BITS-1:0] player2_pos_x,
    output logic              pos_valid,
    output logic              active_player,
    output logic [2:0]        dice_value,
    output logic              game_over,
    output logic              winner
);

    localparam int TMO_W = $clog2(DONE_TIMEOUT);

    turn_state_t          state_q;
    logic [TILE_BITS-1:0] tile1_q, tile2_q;
    logic [2:0]           dice_q;
    logic                 active_q;
    logic                 pos_valid_q;
    logic                 game_over_q;
    logic                 winner_q;
    logic [TMO_W-1:0]     tmo_q;

    logic [2:0]           die_val;
    logic [TILE_BITS-1:0] cur_tile;
    logic [5:0]           sum;
    logic [TILE_BITS-1:0] tile_d;
    logic                 tmo_hit;
    logic                 turn_end;

    die_counter u_die (
        .clk     (clk),
        .rst_n   (rst_n),
        .value_o (die_val)
    );

    assign cur_tile = active_q ? tile2_q : tile1_q;
    assign sum      = 6'(cur_tile) + 6'(dice_q);
    assign tmo_hit  = (tmo_q == TMO_W'(DONE_TIMEOUT - 1));
    assign turn_end = turn_done || tmo_hit;

`ifdef EXACT_FINISH_EN
    assign tile_d = (sum > 6'(LAST_TILE)) ? TILE_BITS'(6'(2 * LAST_TILE) - sum)
                                          : TILE_BITS'(sum);
`else
    assign tile_d = (sum > 6'(LAST_TILE)) ? TILE_BITS'(LAST_TILE) : TILE_BITS'(sum);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tile1_q     <= '0;
            tile2_q     <= '0;
            dice_q      <= '0;
            active_q    <= 1'b0;
            pos_valid_q <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
            tmo_q       <= '0;
        end else begin
            pos_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (roll_req) begin
                        dice_q  <= die_val;
                        state_q <= ST_ROLL;
                    end
                end
                ST_ROLL: begin
                    if (active_q) tile2_q <= tile_d;
                    else          tile1_q <= tile_d;
                    // Pulse lines up with ISSUE, so it is always preceded by a low cycle.
                    pos_valid_q <= 1'b1;
                    state_q     <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    tmo_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (turn_end) begin
                        if (cur_tile == TILE_BITS'(LAST_TILE)) begin
                            game_over_q <= 1'b1;
                            winner_q    <= active_q;
                            state_q     <= ST_OVER;
                        end else begin
                            active_q <= ~active_q;
                            state_q  <= ST_IDLE;
                        end
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ST_OVER: state_q <= ST_OVER;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign player1_pos_x = tile_x(tile1_q);
    assign player2_pos_x = tile_x(tile2_q);
    assign pos_valid     = pos_valid_q;
    assign active_player = active_q;
    assign dice_value    = dice_q;
    assign game_over     = game_over_q;
    assign winner        = winner_q;

endmodule

// File: tb/tb_turn_manager.sv
// Directed bench for turn_manager; expectations are hand-computed tile/x values.
module tb_turn_manager;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       roll_req;
    logic       turn_done;
    logic [9:0] player1_pos_x;
    logic [9:0] player2_pos_x;
    logic       pos_valid;
    logic       active_player;
    logic [2:0] dice_value;
    logic       game_over;
    logic       winner;

    int checks = 0;
    int errors = 0;
    int die_m;

    always #5 clk = ~clk;

    turn_manager dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .roll_req      (roll_req),
        .turn_done     (turn_done),
        .player1_pos_x (player1_pos_x),
        .player2_pos_x (player2_pos_x),
        .pos_valid     (pos_valid),
        .active_player (active_player),
        .dice_value    (dice_value),
        .game_over     (game_over),
        .winner        (winner)
    );

    // Tracks which face the die shows, so rolls can be aimed at a value.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          die_m <= 1;
        else if (die_m == 6) die_m <= 1;
        else                 die_m <= die_m + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_p1x"}, 32'(player1_pos_x), 20);
        chk({tag, "_p2x"}, 32'(player2_pos_x), 20);
        chk({tag, "_pv"},  32'(pos_valid), 0);
        chk({tag, "_ap"},  32'(active_player), 0);
        chk({tag, "_dice"}, 32'(dice_value), 0);
        chk({tag, "_go"},  32'(game_over), 0);
        chk({tag, "_win"}, 32'(winner), 0);
    endtask

    // Present roll_req for exactly the edge where the die shows v; returns one negedge later.
    task automatic roll_with(input int v);
        for (int i = 0; i < 7 && die_m != v; i++) @(negedge clk);
        roll_req = 1'b1;
        @(negedge clk);
        roll_req = 1'b0;
    endtask

    task automatic pulse_done();
        turn_done = 1'b1;
        @(negedge clk);
        turn_done = 1'b0;
    endtask

    // Full turn ending with turn_done; returns in IDLE with the turn handed over.
    task automatic do_turn(input string tag, input int v);
        roll_with(v);
        @(negedge clk);
        chk({tag, "_pv"}, 32'(pos_valid), 1);
        @(negedge clk);
        pulse_done();
    endtask

    initial begin
        rst_n = 1'b0; roll_req = 1'b0; turn_done = 1'b0;
        #12;
        chk_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // First roll: die=3, P1 to tile 3
        roll_with(3);
        chk("t1_dice", 32'(dice_value), 3);
        chk("t1_pv_lo0", 32'(pos_valid), 0);
        chk("t1_p1_old", 32'(player1_pos_x), 20);
        @(negedge clk);
        chk("t1_pv_hi", 32'(pos_valid), 1);
        chk("t1_p1x", 32'(player1_pos_x), 110);
        chk("t1_p2x", 32'(player2_pos_x), 20);
        @(negedge clk);
        chk("t1_pv_lo1", 32'(pos_valid), 0);
        chk("t1_ap_wait", 32'(active_player), 0);
        pulse_done();
        chk("t1_ap", 32'(active_player), 1);

        // roll_req held through WAIT_DONE, turn_done while idle
        for (int i = 0; i < 7 && die_m != 2; i++) @(negedge clk);
        roll_req = 1'b1;
        @(negedge clk);
        chk("t2_dice", 32'(dice_value), 2);
        @(negedge clk);
        chk("t2_pv_hi", 32'(pos_valid), 1);
        chk("t2_p2x", 32'(player2_pos_x), 80);
        chk("t2_p1x", 32'(player1_pos_x), 110);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_pv_held", 32'(pos_valid), 0);
        end
        chk("t2_dice_held", 32'(dice_value), 2);
        chk("t2_ap_held", 32'(active_player), 1);
        roll_req = 1'b0;
        pulse_done();
        chk("t2_ap", 32'(active_player), 0);
        pulse_done();
        chk("t2_idle_done_ap", 32'(active_player), 0);
        chk("t2_idle_done_pv", 32'(pos_valid), 0);
        @(negedge clk);
        chk("t2_idle_pv", 32'(pos_valid), 0);
        chk("t2_idle_dice", 32'(dice_value), 2);

        // P1 rolls 6 -> tile 9
        do_turn("t3", 6);
        chk("t3_p1x", 32'(player1_pos_x), 290);
        chk("t3_ap", 32'(active_player), 1);

        // P2 rolls 1 -> tile 3, no turn_done: turn ends on timeout
        roll_with(1);
        @(negedge clk);
        chk("t5_pv", 32'(pos_valid), 1);
        chk("t5_p2x", 32'(player2_pos_x), 110);
        repeat (127) @(negedge clk);
        chk("t5_ap_before", 32'(active_player), 1);
        @(negedge clk);
        chk("t5_ap_after", 32'(active_player), 0);
        chk("t5_p1x", 32'(player1_pos_x), 290);

        do_turn("t6a", 6);
        chk("t6a_p1x", 32'(player1_pos_x), 470);
        do_turn("t6b", 1);
        chk("t6b_p2x", 32'(player2_pos_x), 140);
        do_turn("t6c", 3);
        chk("t6c_p1x", 32'(player1_pos_x), 560);
        do_turn("t6d", 1);
        chk("t6d_p2x", 32'(player2_pos_x), 170);
        chk("t6d_ap", 32'(active_player), 0);

        // P1 at tile 18 rolls 5
        roll_with(5);
        @(negedge clk);
        chk("t9_pv", 32'(pos_valid), 1);
        chk("t9_p2x", 32'(player2_pos_x), 170);
`ifdef EXACT_FINISH_EN
        chk("t9_p1x", 32'(player1_pos_x), 530);
        @(negedge clk);
        pulse_done();
        chk("t9_go", 32'(game_over), 0);
        chk("t9_ap", 32'(active_player), 1);
`else
        chk("t9_p1x", 32'(player1_pos_x), 620);
        @(negedge clk);
        pulse_done();
        chk("t9_go", 32'(game_over), 1);
        chk("t9_win", 32'(winner), 0);
        chk("t9_ap", 32'(active_player), 0);
        roll_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t9_over_pv", 32'(pos_valid), 0);
        end
        roll_req = 1'b0;
        pulse_done();
        chk("t9_over_dice", 32'(dice_value), 5);
        chk("t9_over_go", 32'(game_over), 1);
        chk("t9_over_p1x", 32'(player1_pos_x), 620);
`endif

        // Fresh game, then async reset in the middle of WAIT_DONE
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_turn("r1", 3);
        chk("r1_p1x", 32'(player1_pos_x), 110);
        roll_with(4);
        @(negedge clk);
        chk("r2_p2x", 32'(player2_pos_x), 140);
        @(negedge clk);
        chk("r2_ap", 32'(active_player), 1);
        #2 rst_n = 1'b0;
        #1 chk_reset("arst");
        @(negedge clk);
        rst_n = 1'b1;
        roll_with(3);
        chk("r3_dice", 32'(dice_value), 3);
        chk("r3_pv_lo0", 32'(pos_valid), 0);
        @(negedge clk);
        chk("r3_pv_hi", 32'(pos_valid), 1);
        chk("r3_p1x", 32'(player1_pos_x), 110);
        chk("r3_p2x", 32'(player2_pos_x), 20);
        @(negedge clk);
        chk("r3_pv_lo1", 32'(pos_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
